alu_arbiter: RTL and testbench

Shares one `Alu` instance between two requesters (for example, the integer execute path and the address-generation path) using a valid/ready request and response handshake. The block arbitrates, captures operands, and sequences a fixed three-state operation. It returns the registered result and the {V,C,N,Z} flags to the winning requester only. It sits between the requesters and the shared ALU, and it is the only block that drives the ALU inputs.

---
 rtl/alu_arbiter.sv | 137 +++++++++++++
 tb/tb_alu_arbiter.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// alu_arbiter: two requesters share one ALU; round-robin grant, or requester 0 first when ALU_ARB_FIXED_PRIO_EN is defined.
// Accept at N, rsp_valid at N+2; RESP holds until the owner's rsp_ready, and req_ready stays low while busy.
module alu_arbiter_alu #(
  parameter int BITS = 64
) (
  input  logic [0:BITS-1] src_a,
  input  logic [0:BITS-1] src_b,
  input  logic [0:1]      alu_control,
  output logic [0:BITS-1] alu_result,
  output logic [0:3]      alu_flags
);
  logic            is_sub;
  logic            is_arith;
  logic [0:BITS-1] b_eff;
  logic [BITS:0]   sum;

  always_comb begin
    is_sub   = (alu_control == 2'b01);
    is_arith = (alu_control == 2'b00) || is_sub;
    b_eff    = is_sub ? ~src_b : src_b;
    sum      = {1'b0, src_a} + {1'b0, b_eff} + {{BITS{1'b0}}, is_sub};
    case (alu_control)
      2'b10:   alu_result = src_a & src_b;
      2'b11:   alu_result = src_a | src_b;
      default: alu_result = sum[BITS-1:0];
    endcase
    // {V,C,N,Z}; bit 0 of a vector is its MSB
    alu_flags = {is_arith & ~(src_a[0] ^ b_eff[0]) & (src_a[0] ^ sum[BITS-1]),
                 is_arith & sum[BITS],
                 alu_result[0],
                 alu_result == '0};
  end
endmodule

module alu_arbiter #(
  parameter int BITS = 64
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req_valid0,
  input  logic            req_valid1,
  output logic            req_ready0,
  output logic            req_ready1,
  input  logic [0:BITS-1] req_a0,
  input  logic [0:BITS-1] req_a1,
  input  logic [0:BITS-1] req_b0,
  input  logic [0:BITS-1] req_b1,
  input  logic [0:1]      req_op0,
  input  logic [0:1]      req_op1,
  output logic            rsp_valid0,
  output logic            rsp_valid1,
  input  logic            rsp_ready0,
  input  logic            rsp_ready1,
  output logic [0:BITS-1] rsp_result,
  output logic [0:3]      rsp_flags,
  output logic            busy
);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EXEC = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  logic [1:0]      state;
  logic            owner;
  logic [0:BITS-1] opnd_a;
  logic [0:BITS-1] opnd_b;
  logic [0:1]      opnd_op;
  logic            prio;
  logic            winner;
  logic            accept;
  logic            rsp_fire;
  logic [0:BITS-1] alu_result;
  logic [0:3]      alu_flags;

  always_comb begin
    winner = req_valid1;
    if (req_valid0 && req_valid1) winner = prio;
  end

  // Gated by rst_n so nobody sees a grant on an edge that will not capture it.
  assign accept     = rst_n && (state == S_IDLE) && (req_valid0 || req_valid1);
  assign req_ready0 = accept && !winner;
  assign req_ready1 = accept && winner;
  assign rsp_valid0 = (state == S_RESP) && !owner;
  assign rsp_valid1 = (state == S_RESP) && owner;
  assign rsp_fire   = (state == S_RESP) && (owner ? rsp_ready1 : rsp_ready0);
  assign busy       = (state != S_IDLE);

`ifdef ALU_ARB_FIXED_PRIO_EN
  assign prio = 1'b0;
`else
  logic ptr;

  always_ff @(posedge clk) begin
    if (!rst_n)      ptr <= 1'b0;
    else if (accept) ptr <= ~winner;
  end

  assign prio = ptr;
`endif

  alu_arbiter_alu #(.BITS(BITS)) u_alu (
    .src_a       (opnd_a),
    .src_b       (opnd_b),
    .alu_control (opnd_op),
    .alu_result  (alu_result),
    .alu_flags   (alu_flags)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      owner      <= 1'b0;
      opnd_a     <= '0;
      opnd_b     <= '0;
      opnd_op    <= '0;
      rsp_result <= '0;
      rsp_flags  <= '0;
    end else begin
      case (state)
        S_IDLE: if (accept) begin
          state   <= S_EXEC;
          owner   <= winner;
          opnd_a  <= winner ? req_a1  : req_a0;
          opnd_b  <= winner ? req_b1  : req_b0;
          opnd_op <= winner ? req_op1 : req_op0;
        end
        S_EXEC: begin
          rsp_result <= alu_result;
          rsp_flags  <= alu_flags;
          state      <= S_RESP;
        end
        S_RESP: if (rsp_fire) state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: directed vectors with literal expectations plus a per-cycle transaction model.
module tb_alu_arbiter;
  localparam int BITS = 64;
`ifdef ALU_ARB_FIXED_PRIO_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif

  typedef struct packed {
    logic [BITS-1:0] res;
    logic [3:0]      flg;   // {V,C,N,Z}
  } ref_t;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            req_valid0 = 1'b0, req_valid1 = 1'b0;
  logic            req_ready0, req_ready1;
  logic [0:BITS-1] req_a0 = '0, req_a1 = '0, req_b0 = '0, req_b1 = '0;
  logic [0:1]      req_op0 = '0, req_op1 = '0;
  logic            rsp_valid0, rsp_valid1;
  logic            rsp_ready0 = 1'b1, rsp_ready1 = 1'b1;
  logic [0:BITS-1] rsp_result;
  logic [0:3]      rsp_flags;
  logic            busy;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int v1_cnt = 0;

  always #5 clk = ~clk;

  alu_arbiter #(.BITS(BITS)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid0(req_valid0), .req_valid1(req_valid1),
    .req_ready0(req_ready0), .req_ready1(req_ready1),
    .req_a0(req_a0), .req_a1(req_a1), .req_b0(req_b0), .req_b1(req_b1),
    .req_op0(req_op0), .req_op1(req_op1),
    .rsp_valid0(rsp_valid0), .rsp_valid1(rsp_valid1),
    .rsp_ready0(rsp_ready0), .rsp_ready1(rsp_ready1),
    .rsp_result(rsp_result), .rsp_flags(rsp_flags), .busy(busy)
  );

  task automatic chk(input string name, input logic [BITS-1:0] act, input logic [BITS-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference ALU from arithmetic definitions: V = signed result out of range, C = unsigned carry / no-borrow.
  function automatic ref_t alu_ref(input logic [BITS-1:0] a, input logic [BITS-1:0] b, input logic [1:0] op);
    ref_t r;
    logic signed [BITS+1:0] sa, sb, st, smax, smin;
    logic v, c;
    sa   = $signed({{2{a[BITS-1]}}, a});
    sb   = $signed({{2{b[BITS-1]}}, b});
    smax = $signed({3'b000, {(BITS-1){1'b1}}});
    smin = -smax - 1;
    v = 1'b0;
    c = 1'b0;
    st = '0;
    case (op)
      2'b00: begin r.res = a + b; st = sa + sb; c = (r.res < a); v = (st > smax) || (st < smin); end
      2'b01: begin r.res = a - b; st = sa - sb; c = (a >= b);    v = (st > smax) || (st < smin); end
      2'b10: r.res = a & b;
      default: r.res = a | b;
    endcase
    r.flg = {v, c, r.res[BITS-1], r.res == '0};
    return r;
  endfunction

  function automatic bit pick(input bit v0, input bit v1, input bit ptr);
    if (v0 && v1) return FIXED ? 1'b0 : ptr;
    return v1;
  endfunction

  // Transaction model: one op in flight; m_age counts edges since accept.
  bit              m_busy = 1'b0, m_owner = 1'b0, m_ptr = 1'b0;
  int              m_age = 0;
  logic [BITS-1:0] m_res = '0, m_pres = '0;
  logic [3:0]      m_flg = '0, m_pflg = '0;
  bit              pick_w;
  ref_t            nxt_ref;

  assign pick_w  = pick(req_valid0, req_valid1, m_ptr);
  assign nxt_ref = pick_w ? alu_ref(req_a1, req_b1, req_op1) : alu_ref(req_a0, req_b0, req_op0);

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!rst_n) begin
      m_busy <= 1'b0; m_age <= 0; m_owner <= 1'b0; m_ptr <= 1'b0;
      m_res <= '0; m_flg <= '0;
    end else if (!m_busy) begin
      if (req_valid0 || req_valid1) begin
        m_busy <= 1'b1; m_age <= 0; m_owner <= pick_w; m_ptr <= !pick_w;
        m_pres <= nxt_ref.res; m_pflg <= nxt_ref.flg;
      end
    end else begin
      if (m_age == 0) begin m_res <= m_pres; m_flg <= m_pflg; end
      if (m_age >= 1 && (m_owner ? rsp_ready1 : rsp_ready0)) m_busy <= 1'b0;
      m_age <= m_age + 1;
    end
  end

  always @(negedge clk) begin
    if (rsp_valid1 === 1'b1) v1_cnt <= v1_cnt + 1;
    if (cyc >= 1) begin
      chk("cmp req_ready0", req_ready0, rst_n && !m_busy && (req_valid0 || req_valid1) && !pick_w);
      chk("cmp req_ready1", req_ready1, rst_n && !m_busy && (req_valid0 || req_valid1) && pick_w);
      chk("cmp rsp_valid0", rsp_valid0, m_busy && m_age >= 1 && !m_owner);
      chk("cmp rsp_valid1", rsp_valid1, m_busy && m_age >= 1 && m_owner);
      chk("cmp busy", busy, m_busy);
      chk("cmp rsp_result", rsp_result, m_res);
      chk("cmp rsp_flags", rsp_flags, m_flg);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input bit who, input bit vld, input logic [BITS-1:0] a,
                         input logic [BITS-1:0] b, input logic [1:0] op);
    if (who) begin req_valid1 = vld; req_a1 = a; req_b1 = b; req_op1 = op; end
    else     begin req_valid0 = vld; req_a0 = a; req_b0 = b; req_op0 = op; end
  endtask

  task automatic wait_ready(input bit who, input string nm, output int acc);
    bit got = 1'b0;
    acc = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (who ? req_ready1 : req_ready0) begin got = 1'b1; acc = cyc; break; end
    end
    chk({nm, " accept"}, got, 1'b1);
  endtask

  task automatic wait_rsp(input bit who, input string nm);
    bit got = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (who ? rsp_valid1 : rsp_valid0) begin got = 1'b1; break; end
    end
    chk({nm, " response"}, got, 1'b1);
  endtask

  // Called at posedge+1 with the DUT idle; returns at posedge+1 after the response handshake.
  task automatic do_op(input bit who, input logic [BITS-1:0] a, input logic [BITS-1:0] b,
                       input logic [1:0] op, input logic [BITS-1:0] eres, input logic [3:0] eflg,
                       input string nm);
    int acc;
    set_req(who, 1'b1, a, b, op);
    wait_ready(who, nm, acc);
    tick();
    set_req(who, 1'b0, a, b, op);
    wait_rsp(who, nm);
    chk({nm, " latency"}, cyc - acc, 2);
    chk({nm, " result"}, rsp_result, eres);
    chk({nm, " flags"}, rsp_flags, eflg);
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
    $fatal(1);
  end

  initial begin
    ref_t r;
    int acc, hs, n0;
    bit w;

    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("reset busy", busy, 1'b0);
    chk("reset rsp_result", rsp_result, 0);
    chk("reset rsp_flags", rsp_flags, 0);
    chk("reset rsp_valid0", rsp_valid0, 1'b0);

    r = alu_ref(64'd5, 64'd7, 2'b00);
    chk("model add res", r.res, 64'd12);
    chk("model add flg", r.flg, 4'b0000);
    r = alu_ref(64'd9, 64'd9, 2'b01);
    chk("model subz flg", r.flg, 4'b0101);
    r = alu_ref(64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 2'b00);
    chk("model ovf res", r.res, 64'h8000_0000_0000_0000);
    chk("model ovf flg", r.flg, 4'b1010);
    r = alu_ref(64'd3, 64'd5, 2'b01);
    chk("model borrow flg", r.flg, 4'b0010);
    tick();

    // Contention straight after reset: pointer starts at 0.
    set_req(1'b0, 1'b1, 64'hF0, 64'h0F, 2'b11);
    set_req(1'b1, 1'b1, 64'h100, 64'h001, 2'b11);
    for (int g = 0; g < 4; g++) begin
      bit got = 1'b0;
      for (int i = 0; i < 20; i++) begin
        @(negedge clk);
        if (req_ready0 || req_ready1) begin got = 1'b1; break; end
      end
      chk("rr accept", got, 1'b1);
      w = req_ready1;
      chk("rr grant order", w, FIXED ? (g == 3) : (g % 2 == 1));
      tick();
      if (w) req_valid1 = 1'b0; else req_valid0 = 1'b0;
      wait_rsp(w, "rr");
      chk("rr result", rsp_result, w ? 64'h101 : 64'hFF);
      chk("rr flags", rsp_flags, 4'b0000);
      tick();
      if (g < 2) begin
        if (w) req_valid1 = 1'b1; else req_valid0 = 1'b1;
      end
    end

    n0 = v1_cnt;
    do_op(1'b0, 64'd5, 64'd7, 2'b00, 64'd12, 4'b0000, "add5+7");
    chk("add5+7 no rsp_valid1", v1_cnt, n0);
    do_op(1'b1, 64'd9, 64'd9, 2'b01, 64'd0, 4'b0101, "sub9-9");
    do_op(1'b0, 64'd3, 64'd5, 2'b01, 64'hFFFF_FFFF_FFFF_FFFE, 4'b0010, "sub3-5");
    do_op(1'b0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 2'b00, 64'h8000_0000_0000_0000, 4'b1010, "ovf");
    do_op(1'b1, 64'hFF00, 64'h0FF0, 2'b10, 64'h0F00, 4'b0000, "and");

    // Response stall on requester 0 while requester 1 waits.
    rsp_ready0 = 1'b0;
    set_req(1'b0, 1'b1, 64'h1234, 64'h1, 2'b00);
    wait_ready(1'b0, "stall", acc);
    tick();
    req_valid0 = 1'b0;
    set_req(1'b1, 1'b1, 64'h20, 64'h3, 2'b01);
    wait_rsp(1'b0, "stall");
    for (int k = 0; k < 10; k++) begin
      chk("stall result", rsp_result, 64'h1235);
      chk("stall busy", busy, 1'b1);
      chk("stall req_ready1", req_ready1, 1'b0);
      chk("stall rsp_valid0", rsp_valid0, 1'b1);
      tick();
      @(negedge clk);
    end
    rsp_ready0 = 1'b1;
    hs = cyc;
    @(negedge clk);
    chk("release idle", busy, 1'b0);
    chk("release req_ready1", req_ready1, 1'b1);
    chk("release cycle", cyc - hs, 1);
    tick();
    req_valid1 = 1'b0;
    wait_rsp(1'b1, "after stall");
    chk("after stall result", rsp_result, 64'h1D);
    chk("after stall flags", rsp_flags, 4'b0100);
    tick();

    // Reset while in RESP aborts the operation.
    rsp_ready1 = 1'b0;
    set_req(1'b1, 1'b1, 64'd2, 64'd2, 2'b00);
    wait_ready(1'b1, "rst", acc);
    tick();
    req_valid1 = 1'b0;
    wait_rsp(1'b1, "rst");
    chk("rst pre rsp_result", rsp_result, 64'd4);
    tick();
    rst_n = 1'b0;
    tick();
    @(negedge clk);
    chk("rst busy", busy, 1'b0);
    chk("rst rsp_valid1", rsp_valid1, 1'b0);
    chk("rst rsp_result", rsp_result, 0);
    chk("rst rsp_flags", rsp_flags, 0);
    tick();
    rst_n = 1'b1;
    rsp_ready1 = 1'b1;
    n0 = v1_cnt;
    repeat (5) tick();
    chk("rst no replay", v1_cnt, n0);
    do_op(1'b1, 64'd6, 64'd3, 2'b01, 64'd3, 4'b0100, "post rst");

    repeat (3) tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
